// File: rtl/gs_bfu_intt_pkg.sv
// Shared constants for the GS inverse-NTT butterfly: Barrett parameters,
// the modular inverse of two, and the fixed pipeline depth.
package ntt_pkg;

    function automatic int unsigned calc_k(input int unsigned q);
        return $clog2(q);
    endfunction

    // floor(4^K / q), the Barrett reciprocal for a K-bit modulus
    function automatic longint unsigned calc_mu(input int unsigned q);
        longint unsigned four_k;
        four_k = 64'd1 << (2 * $clog2(q));
        return four_k / 64'(q);
    endfunction

    localparam int unsigned     Q       = 7681;
    localparam int unsigned     K       = calc_k(Q);
    localparam longint unsigned MU      = calc_mu(Q);
    localparam int unsigned     INV2    = (Q + 1) / 2;
    localparam int unsigned     LATENCY = 5;

endpackage

// File: rtl/gs_bfu_intt_if.sv
// Operand/result bundle of the GS butterfly; the producer drives the master
// side, the butterfly sits on the slave side.
interface gs_bfu_intt_if #(
    parameter int unsigned data_width = 64
);
    logic                  en;
    logic                  valid_in;
    logic [data_width-1:0] a;
    logic [data_width-1:0] b;
    logic [data_width-1:0] tw_factor;
    logic                  halve;
    logic                  valid_out;
    logic [data_width-1:0] mod_sum_out;
    logic [data_width-1:0] mod_mul_out;

    modport master (
        output en, valid_in, a, b, tw_factor, halve,
        input  valid_out, mod_sum_out, mod_mul_out
    );

    modport slave (
        input  en, valid_in, a, b, tw_factor, halve,
        output valid_out, mod_sum_out, mod_mul_out
    );
endinterface

// File: rtl/gs_bfu_intt_barrett_reduce_pipe.sv
// Three-stage Barrett reduction of a product p < q^2 to [0, q), with an
// optional final multiply by 2^-1 mod q.
module barrett_reduce_pipe
    import ntt_pkg::*;
#(
    parameter  int unsigned modulo = Q,
    localparam int unsigned KB     = calc_k(modulo)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2*KB-1:0] p,
    input  logic            halve,
    output logic [KB-1:0]   res
);

    localparam longint unsigned MU_L  = calc_mu(modulo);
    localparam logic [KB:0]     MU_V  = (KB+1)'(MU_L);
    localparam logic [KB+1:0]   Q_X   = (KB+2)'(modulo);
    localparam logic [KB+1:0]   Q2_X  = (KB+2)'(2 * modulo);
    localparam logic [KB-1:0]   INV2K = KB'((modulo + 1) / 2);

    logic [2*KB+1:0] est;
    logic [KB:0]     qhat_p3;
    logic [KB+1:0]   plo_p3;
    logic            halve_p3;
    logic [KB+1:0]   r_p4;
    logic            halve_p4;
    logic [KB-1:0]   res_p5;

    // r lands in [0, 3q); two conditional subtracts finish the reduction
    function automatic logic [KB-1:0] reduce_halve(input logic [KB+1:0] r, input logic h);
        logic [KB+1:0] v;
        logic [KB-1:0] red;
        v = r;
        if (v >= Q2_X)
            v = v - Q2_X;
        else if (v >= Q_X)
            v = v - Q_X;
        red = KB'(v);
        // odd v: (v+q)/2 == (v>>1) + (q+1)/2, avoiding a carry bit
        if (h)
            red = red[0] ? (red >> 1) + INV2K : (red >> 1);
        return red;
    endfunction

    always_comb est = (2*KB+2)'(p[2*KB-1:KB-1]) * (2*KB+2)'(MU_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            qhat_p3  <= '0;
            plo_p3   <= '0;
            halve_p3 <= 1'b0;
            r_p4     <= '0;
            halve_p4 <= 1'b0;
            res_p5   <= '0;
        end else if (en) begin
            // S3: quotient estimate
            qhat_p3  <= (KB+1)'(est >> (KB+1));
            plo_p3   <= p[KB+1:0];
            halve_p3 <= halve;
            // S4: remainder in K+2 bits
            r_p4     <= plo_p3 - (KB+2)'(qhat_p3) * Q_X;
            halve_p4 <= halve_p3;
            // S5: final correction and optional halving
            res_p5   <= reduce_halve(r_p4, halve_p4);
        end
    end

    assign res = res_p5;

endmodule

// File: rtl/gs_bfu_intt.sv
// Gentleman-Sande inverse-NTT butterfly: x = (a+b) mod q, y = ((a-b)*w) mod q,
// each optionally scaled by 2^-1 mod q; five enabled cycles from input to output.
module gs_bfu_intt
    import ntt_pkg::*;
#(
    parameter int unsigned data_width = 64,
    parameter int unsigned modulo     = 7681
) (
    input logic          clk,
    input logic          rst,
    gs_bfu_intt_if.slave bus
);

    localparam int unsigned         KW     = calc_k(modulo);
    localparam logic [data_width-1:0] Q_W    = data_width'(modulo);
    localparam logic [data_width-1:0] INV2_W = data_width'((modulo + 1) / 2);

    logic [data_width-1:0]   sum_s1;
    logic [data_width-1:0]   diff_s1;
    logic [2*data_width-1:0] prod_s2;
    logic [2*KW-1:0]         pclamp_s2;

    logic [data_width-1:0] s_p1, d_p1, tw_p1;
    logic                  halve_p1, vld_p1;
    logic [2*KW-1:0]       p_p2;
    logic [data_width-1:0] s_p2, s_p3, s_p4, sum_p5;
    logic                  halve_p2, halve_p3, halve_p4;
    logic                  vld_p2, vld_p3, vld_p4, vld_p5;
    logic [KW-1:0]         mul_res;

    function automatic logic [data_width-1:0] halve_mod(input logic [data_width-1:0] v, input logic h);
        if (!h)
            return v;
        return v[0] ? (v >> 1) + INV2_W : (v >> 1);
    endfunction

    // Comparing a against q-b detects the wrap without needing a carry bit
    always_comb begin
        sum_s1 = bus.a + bus.b;
        if (bus.a >= Q_W - bus.b)
            sum_s1 = bus.a + bus.b - Q_W;
        diff_s1 = bus.a - bus.b;
        if (bus.a < bus.b)
            diff_s1 = diff_s1 + Q_W;
    end

    // In-contract products fit 2K bits; anything wider saturates to a harmless value
    always_comb begin
        prod_s2   = {{data_width{1'b0}}, d_p1} * {{data_width{1'b0}}, tw_p1};
        pclamp_s2 = (|prod_s2[2*data_width-1:2*KW]) ? '1 : prod_s2[2*KW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1     <= '0;
            d_p1     <= '0;
            tw_p1    <= '0;
            halve_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            p_p2     <= '0;
            s_p2     <= '0;
            halve_p2 <= 1'b0;
            vld_p2   <= 1'b0;
            s_p3     <= '0;
            halve_p3 <= 1'b0;
            vld_p3   <= 1'b0;
            s_p4     <= '0;
            halve_p4 <= 1'b0;
            vld_p4   <= 1'b0;
            sum_p5   <= '0;
            vld_p5   <= 1'b0;
        end else if (bus.en) begin
            // S1: modular add/sub
            s_p1     <= sum_s1;
            d_p1     <= diff_s1;
            tw_p1    <= bus.tw_factor;
            halve_p1 <= bus.halve;
            vld_p1   <= bus.valid_in;
            // S2: twiddle multiply
            p_p2     <= pclamp_s2;
            s_p2     <= s_p1;
            halve_p2 <= halve_p1;
            vld_p2   <= vld_p1;
            // S3-S4: sum path waits while the product is reduced
            s_p3     <= s_p2;
            halve_p3 <= halve_p2;
            vld_p3   <= vld_p2;
            s_p4     <= s_p3;
            halve_p4 <= halve_p3;
            vld_p4   <= vld_p3;
            // S5: output register
            sum_p5   <= halve_mod(s_p4, halve_p4);
            vld_p5   <= vld_p4;
        end
    end

    barrett_reduce_pipe #(
        .modulo (modulo)
    ) u_barrett (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .p     (p_p2),
        .halve (halve_p2),
        .res   (mul_res)
    );

    assign bus.valid_out   = vld_p5;
    assign bus.mod_sum_out = sum_p5;
    assign bus.mod_mul_out = {{(data_width-KW){1'b0}}, mul_res};

endmodule

// File: tb/tb_gs_bfu_intt.sv
// Bench for the GS inverse-NTT butterfly: directed and random vectors against
// a plain-arithmetic modular reference with a latency-tagged scoreboard.
module tb_gs_bfu_intt;
    import ntt_pkg::*;

    localparam int DW = 64;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        int          due;
        bit          dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int          en_cnt = 0;
    exp_t        sb[$];
    bit          exp_v = 1'b0;
    bit          exp_dc = 1'b0;
    logic [63:0] exp_x = '0;
    logic [63:0] exp_y = '0;

    gs_bfu_intt_if #(.data_width(DW)) bus_if ();

    gs_bfu_intt #(.data_width(DW), .modulo(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic void model(input longint unsigned a, input longint unsigned b,
                                  input longint unsigned w, input bit h,
                                  output logic [63:0] x, output logic [63:0] y);
        longint unsigned xs, ys;
        xs = (a + b) % Q;
        ys = (((a + Q - b) % Q) * w) % Q;
        if (h) begin
            xs = (xs * INV2) % Q;
            ys = (ys * INV2) % Q;
        end
        x = xs;
        y = ys;
    endfunction

    task automatic step(input bit e, input bit r, input bit v,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] w,
                        input bit h, input bit dc = 1'b0);
        logic [63:0] x, y;
        bus_if.en        = e;
        rst              = r;
        bus_if.valid_in  = v;
        bus_if.a         = a;
        bus_if.b         = b;
        bus_if.tw_factor = w;
        bus_if.halve     = h;
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            exp_v  = 1'b0;
            exp_dc = 1'b0;
            exp_x  = '0;
            exp_y  = '0;
        end else if (e) begin
            en_cnt++;
            if (v) begin
                model(a, b, w, h, x, y);
                sb.push_back('{x: x, y: y, due: en_cnt + int'(LATENCY) - 1, dc: dc});
            end
            exp_v = 1'b0;
            if (sb.size() > 0 && sb[0].due == en_cnt) begin
                exp_v  = 1'b1;
                exp_x  = sb[0].x;
                exp_y  = sb[0].y;
                exp_dc = sb[0].dc;
                void'(sb.pop_front());
            end
        end
        check("valid_out", {63'b0, bus_if.valid_out}, {63'b0, exp_v});
        if (r || (exp_v && !exp_dc)) begin
            check("mod_sum_out", bus_if.mod_sum_out, exp_x);
            check("mod_mul_out", bus_if.mod_mul_out, exp_y);
        end
    endtask

    task automatic rand_vec(input bit e, input bit r);
        logic [63:0] ra, rb, rw;
        ra = 64'($urandom_range(Q - 1));
        rb = 64'($urandom_range(Q - 1));
        rw = 64'($urandom_range(Q - 1));
        step(e, r, 1'b1, ra, rb, rw, 1'($urandom_range(1)));
    endtask

    initial begin
        bus_if.en        = 1'b1;
        bus_if.valid_in  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.tw_factor = '0;
        bus_if.halve     = 1'b0;

        step(1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        check("idle_sum_zero", bus_if.mod_sum_out, 64'd0);
        check("idle_mul_zero", bus_if.mod_mul_out, 64'd0);

        // Directed corner cases, back to back
        step(1'b1, 1'b0, 1'b1, 64'd5,    64'd3,    64'd2,    1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd3,    64'd5,    64'd2,    1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd1,    64'd0,    64'd1,    1'b1);
        step(1'b1, 1'b0, 1'b1, 64'd5,    64'd3,    64'd2,    1'b1);
        step(1'b1, 1'b0, 1'b1, 64'd7680, 64'd7680, 64'd7680, 1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd1,    64'd0,    64'd7680, 1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd7000, 64'd681,  64'd5,    1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd4321, 64'd4321, 64'd99,   1'b1);
        step(1'b1, 1'b0, 1'b1, 64'd7680, 64'd1,    64'd7680, 1'b1);
        step(1'b1, 1'b0, 1'b1, '1, '1, '1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Random stream with a 3-cycle stall and a reset mid-flight
        for (int i = 0; i < 20; i++) begin
            if (i == 8)
                for (int s = 0; s < 3; s++)
                    rand_vec(1'b0, 1'b0);
            if (i == 15)
                rand_vec(1'b1, 1'b1);
            else
                rand_vec(1'b1, 1'b0);
        end
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);

        // In-flight work must vanish on reset
        rand_vec(1'b1, 1'b0);
        rand_vec(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        check("post_reset_sum_zero", bus_if.mod_sum_out, 64'd0);
        check("post_reset_mul_zero", bus_if.mod_mul_out, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
